// File: rtl/counter_cmd_sequencer.sv
// ============================================================================
// Module   : counter_cmd_sequencer
// Purpose  : Queues NOP/LOAD/MODE/WAIT commands in a FIFO and sequences them
//            onto the load/din/mode_cntrl controls of a loadable up/down counter.
//            Optional CMD_COUNT_EN adds an 8-bit completed-command counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       load,
  output logic [3:0] din,
  output logic       mode_cntrl,
  output logic       busy,
  output logic       done
`ifdef CMD_COUNT_EN
  ,
  output logic [7:0] cmd_count
`endif
);

  localparam int           AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]  DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0]   OP_LOAD = 2'b01;
  localparam logic [1:0]   OP_MODE = 2'b10;
  localparam logic [1:0]   OP_WAIT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    wait_cnt;
  logic          push;
  logic          pop;
  logic [1:0]    head_op;
  logic [3:0]    head_data;

  // Ready comes only from the registered count, so a pop never frees a slot
  // in the same cycle it happens.
  assign cmd_ready           = (count < DEPTH);
  assign push                = cmd_valid && cmd_ready;
  assign pop                 = (state == ST_IDLE) && (count != '0);
  assign {head_op, head_data} = mem[rd_ptr];
  assign busy                = (count != '0) || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {cmd_op, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      load       <= 1'b0;
      din        <= '0;
      mode_cntrl <= 1'b0;
      done       <= 1'b0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (head_op == OP_WAIT) begin
              state    <= ST_WAIT;
              wait_cnt <= head_data;
              done     <= (head_data == 4'd0);
            end else begin
              state <= ST_EXEC;
              done  <= 1'b1;
              if (head_op == OP_LOAD) begin
                load <= 1'b1;
                din  <= head_data;
              end
              if (head_op == OP_MODE) begin
                mode_cntrl <= head_data[0];
              end
            end
          end
        end
        ST_EXEC: state <= ST_IDLE;
        ST_WAIT: begin
          // done is raised one edge early so it lines up with wait_cnt == 0
          if (wait_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
            done     <= (wait_cnt == 4'd1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CMD_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_count <= '0;
    end else if (done) begin
      cmd_count <= cmd_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_sequencer.sv
// Testbench for counter_cmd_sequencer: directed scenarios plus randomized
// commands, checked against a timing-level reference model and a done scoreboard.
`default_nettype none

module tb_counter_cmd_sequencer;

  localparam int         DEPTH   = 4;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_MODE = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_data = '0;
  logic       cmd_ready, load, mode_cntrl, busy, done;
  logic [3:0] din;
`ifdef CMD_COUNT_EN
  logic [7:0] cmd_count;
`endif

  counter_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .load       (load),
    .din        (din),
    .mode_cntrl (mode_cntrl),
    .busy       (busy),
    .done       (done)
`ifdef CMD_COUNT_EN
    ,
    .cmd_count  (cmd_count)
`endif
  );

  always #5 clk = ~clk;

  // a: accept edge, p: pop edge, d: edge after which done is shown
  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    int         a;
    int         p;
    int         d;
    logic [3:0] exp_din;
    logic       exp_mode;
  } cmd_t;

  cmd_t       sched[$];
  cmd_t       sb[$];
  int         edge_n = 0;
  int         last_d = 0;
  logic [3:0] m_din = '0, acc_din = '0;
  logic       m_mode = 1'b0, acc_mode = 1'b0;
  int         m_count = 0;
  int         n_cmp = 0, n_bad = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Command-level model: a command pops once it is queued and the sequencer
  // has had its IDLE cycle after the previous command's done; it finishes
  // immediately (NOP/LOAD/MODE) or n edges later (WAIT n).
  task automatic model_edge(input logic r, input logic v, input logic [1:0] op, input logic [3:0] d);
    int   k;
    int   occ;
    cmd_t c;
    k = edge_n;
    if (r) begin
      sched.delete();
      sb.delete();
      last_d   = k - 1;
      m_din    = '0;
      m_mode   = 1'b0;
      acc_din  = '0;
      acc_mode = 1'b0;
      m_count  = 0;
      return;
    end
    occ = 0;
    foreach (sched[i]) if (sched[i].p > k - 1) occ++;
    if (v && occ < DEPTH) begin
      c.op   = op;
      c.data = d;
      c.a    = k;
      c.p    = (k + 1 > last_d + 2) ? k + 1 : last_d + 2;
      c.d    = c.p + ((op == OP_WAIT) ? int'(d) : 0);
      last_d = c.d;
      if (op == OP_LOAD) acc_din = d;
      if (op == OP_MODE) acc_mode = d[0];
      c.exp_din  = acc_din;
      c.exp_mode = acc_mode;
      sched.push_back(c);
      sb.push_back(c);
    end
    foreach (sched[i]) begin
      if (sched[i].p == k && sched[i].op == OP_LOAD) m_din = sched[i].data;
      if (sched[i].p == k && sched[i].op == OP_MODE) m_mode = sched[i].data[0];
      if (sched[i].d == k) m_count = (m_count + 1) % 256;
    end
    while (sched.size() != 0 && sched[0].d < k) void'(sched.pop_front());
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [3:0] d);
    @(negedge clk);
    rst       = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    edge_n++;
    model_edge(r, v, op, d);
  endtask

  always @(negedge clk) begin
    int   k;
    int   occ;
    bit   infl, dexp, lexp;
    cmd_t e;
    if (mon_en) begin
      k = edge_n;
      occ = 0; infl = 0; dexp = 0; lexp = 0;
      foreach (sched[i]) begin
        if (sched[i].p > k) occ++;
        else if (sched[i].d >= k) infl = 1;
        if (sched[i].d == k) dexp = 1;
        if (sched[i].p == k && sched[i].op == OP_LOAD) lexp = 1;
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(occ < DEPTH));
      chk("busy", 32'(busy), 32'(occ > 0 || infl));
      chk("done", 32'(done), 32'(dexp));
      chk("load", 32'(load), 32'(lexp));
      chk("din", 32'(din), 32'(m_din));
      chk("mode_cntrl", 32'(mode_cntrl), 32'(m_mode));
`ifdef CMD_COUNT_EN
      chk("cmd_count", 32'(cmd_count), 32'(m_count));
`endif
      while (sb.size() != 0 && sb[0].d < k) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_missing at edge %0d: no done for op %0d due at edge %0d", k, sb[0].op, sb[0].d);
        void'(sb.pop_front());
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_done at edge %0d: got done with no command pending", k);
        end else begin
          e = sb.pop_front();
          chk("sb_done_edge", 32'(k), 32'(e.d));
          chk("sb_din", 32'(din), 32'(e.exp_din));
          chk("sb_mode", 32'(mode_cntrl), 32'(e.exp_mode));
          chk("sb_load", 32'(load), 32'(e.op == OP_LOAD));
        end
      end
    end
  end

  initial begin
    step(1, 0, OP_NOP, 0);
    step(1, 1, OP_LOAD, 4'hF);
    mon_en = 1'b1;
    step(0, 1, OP_LOAD, 4'b0011);
    repeat (4) step(0, 0, OP_NOP, 0);
    step(0, 1, OP_MODE, 4'd1);
    step(0, 1, OP_LOAD, 4'b1110);
    step(0, 1, OP_WAIT, 4'd3);
    repeat (10) step(0, 0, OP_NOP, 0);
    step(0, 1, OP_WAIT, 4'd15);
    for (int i = 0; i < 20; i++) step(0, 1, OP_LOAD, 4'(i));
    repeat (40) step(0, 0, OP_NOP, 0);
    step(0, 1, OP_WAIT, 4'd0);
    step(0, 1, OP_NOP, 4'd0);
    repeat (5) step(0, 0, OP_NOP, 0);
    step(0, 1, OP_WAIT, 4'd8);
    step(0, 1, OP_LOAD, 4'd9);
    step(0, 1, OP_MODE, 4'd1);
    repeat (3) step(0, 0, OP_NOP, 0);
    step(1, 1, OP_LOAD, 4'd5);
    repeat (4) step(0, 0, OP_NOP, 0);
    repeat (257) step(0, 1, OP_NOP, 4'($urandom));
    repeat (3000) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6),
           2'($urandom_range(0, 3)), 4'($urandom));
    end
    repeat (150) step(0, 0, OP_NOP, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
